// File: rtl/turfio_packer_pkg.sv
// Shared types and constants for the TURFIO frame packer and its skid buffer.
package turfio_packer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [7:0]        HDR_MAGIC = 8'hA5;
    localparam logic [KEEP_W-1:0] KEEP_FULL = 8'hFF;
    localparam logic [KEEP_W-1:0] KEEP_LOW  = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_DROP
    } state_e;

    // One 64-bit output beat: data + keep + last (73 bits).
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

endpackage

// File: rtl/axis_skid64.sv
// Two-entry skid buffer for 73-bit beats; upstream ready is a registered "skid empty".
module axis_skid64
    import turfio_packer_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  s_valid_i,
    input  beat_t s_beat_i,
    output logic  s_ready_o,
    output logic  m_valid_o,
    output beat_t m_beat_o,
    input  logic  m_ready_i
);

    beat_t out_q;
    beat_t skid_q;
    logic  out_vld_q;
    logic  skid_vld_q;
    logic  load_out;
    logic  push;

    assign load_out  = !out_vld_q || m_ready_i;
    assign push      = s_valid_i && !skid_vld_q;
    assign s_ready_o = !skid_vld_q;
    assign m_valid_o = out_vld_q;
    assign m_beat_o  = out_q;

    // Output register refills from the skid entry first, then from the input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (load_out) begin
            if (skid_vld_q) begin
                out_q      <= skid_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q <= push;
                if (push) begin
                    out_q <= s_beat_i;
                end
            end
        end else if (push) begin
            skid_q     <= s_beat_i;
            skid_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/turfio_frame_packer.sv
// Packs a 32-bit Aurora stream into 64-bit beats with keep/last, truncating
// frames longer than MAX_WORDS. Optional header beat: TURFIO_PACKER_HEADER_EN.
module turfio_frame_packer
    import turfio_packer_pkg::*;
#(
    parameter int unsigned LINK_ID   = 0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                aclk,
    input  logic                event_reset,
    input  logic [WORD_W-1:0]   s_aurora_tdata,
    input  logic                s_aurora_tvalid,
    output logic                s_aurora_tready,
    input  logic                s_aurora_tlast,
    output logic [DATA_W-1:0]   m_frame_tdata,
    output logic [KEEP_W-1:0]   m_frame_tkeep,
    output logic                m_frame_tlast,
    output logic                m_frame_tvalid,
    input  logic                m_frame_tready,
    output logic [31:0]         frame_count_o,
    output logic [CNT_W-1:0]    trunc_count_o,
    output logic                frame_active_o
);

    if (LINK_ID > 3 || MAX_WORDS < 2 || MAX_WORDS > 65535) begin : g_param_err
        $error("turfio_frame_packer: LINK_ID or MAX_WORDS out of range");
    end

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [31:0]         frame_q, frame_d;
    logic [CNT_W-1:0]    trunc_q, trunc_d;
    logic                active_q, active_d;
    logic                push_c;
    beat_t               push_beat_c;
    logic                skid_ready;
    logic                accept;
    logic                at_max;
    logic                beat_last;
    beat_t               out_beat;

    // Ready decodes registered state and the skid's registered free-entry flag.
    assign s_aurora_tready = (state_q == ST_DROP) ||
                             (((state_q == ST_LO) || (state_q == ST_HI)) && skid_ready);
    assign accept    = s_aurora_tvalid && s_aurora_tready;
    assign at_max    = (17'(wcnt_q) + 17'd1) == 17'(MAX_WORDS);
    assign beat_last = s_aurora_tlast || at_max;

    // Next-state, packing and counter update logic.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        wcnt_d      = wcnt_q;
        frame_d     = frame_q;
        trunc_d     = trunc_q;
        active_d    = active_q;
        push_c      = 1'b0;
        push_beat_c = '0;
        case (state_q)
            ST_IDLE: begin
                wcnt_d = '0;
                if (s_aurora_tvalid) begin
`ifdef TURFIO_PACKER_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_LO;
`endif
                end
            end
`ifdef TURFIO_PACKER_HEADER_EN
            ST_HDR: begin
                if (skid_ready) begin
                    push_c      = 1'b1;
                    push_beat_c = '{data: {HDR_MAGIC, 6'b0, 2'(LINK_ID), 16'h0000, frame_q},
                                    keep: KEEP_FULL, last: 1'b0};
                    state_d     = ST_LO;
                end
            end
`endif
            ST_LO, ST_HI: begin
                if (accept) begin
                    wcnt_d   = wcnt_q + 16'd1;
                    active_d = 1'b1;
                    if (state_q == ST_HI) begin
                        push_c      = 1'b1;
                        push_beat_c = '{data: {s_aurora_tdata, lo_q}, keep: KEEP_FULL,
                                        last: beat_last};
                        state_d     = ST_LO;
                    end else if (beat_last) begin
                        push_c      = 1'b1;
                        push_beat_c = '{data: {32'h0, s_aurora_tdata}, keep: KEEP_LOW,
                                        last: 1'b1};
                    end else begin
                        lo_d    = s_aurora_tdata;
                        state_d = ST_HI;
                    end
                    if (beat_last) begin
                        active_d = 1'b0;
                        frame_d  = frame_q + 32'd1;
                        if (s_aurora_tlast) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                            if (trunc_q != 16'hFFFF) begin
                                trunc_d = trunc_q + 16'd1;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_aurora_tvalid && s_aurora_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, held low word and counters.
    always_ff @(posedge aclk) begin
        if (event_reset) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            wcnt_q   <= '0;
            frame_q  <= '0;
            trunc_q  <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            wcnt_q   <= wcnt_d;
            frame_q  <= frame_d;
            trunc_q  <= trunc_d;
            active_q <= active_d;
        end
    end

    axis_skid64 u_skid (
        .clk_i     (aclk),
        .rst_i     (event_reset),
        .s_valid_i (push_c),
        .s_beat_i  (push_beat_c),
        .s_ready_o (skid_ready),
        .m_valid_o (m_frame_tvalid),
        .m_beat_o  (out_beat),
        .m_ready_i (m_frame_tready)
    );

    assign m_frame_tdata  = out_beat.data;
    assign m_frame_tkeep  = out_beat.keep;
    assign m_frame_tlast  = out_beat.last;
    assign frame_count_o  = frame_q;
    assign trunc_count_o  = trunc_q;
    assign frame_active_o = active_q;

endmodule

// File: tb/tb_turfio_frame_packer.sv
// Bench for turfio_frame_packer: frame-level packing model + directed literal vectors.
// Build with TURFIO_PACKER_HEADER_EN defined to exercise the header beat.
module tb_turfio_frame_packer;

    localparam int unsigned MAXW = 4;
    localparam int unsigned LID  = 2;
`ifdef TURFIO_PACKER_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic        aclk = 1'b0;
    logic        event_reset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] frame_count;
    logic [15:0] trunc_count;
    logic        frame_active;

    turfio_frame_packer #(.LINK_ID(LID), .MAX_WORDS(MAXW)) dut (
        .aclk            (aclk),
        .event_reset     (event_reset),
        .s_aurora_tdata  (s_tdata),
        .s_aurora_tvalid (s_tvalid),
        .s_aurora_tready (s_tready),
        .s_aurora_tlast  (s_tlast),
        .m_frame_tdata   (m_tdata),
        .m_frame_tkeep   (m_tkeep),
        .m_frame_tlast   (m_tlast),
        .m_frame_tvalid  (m_tvalid),
        .m_frame_tready  (m_tready),
        .frame_count_o   (frame_count),
        .trunc_count_o   (trunc_count),
        .frame_active_o  (frame_active)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Expected beats, produced by the frame-level model.
    logic [63:0] exp_data[$];
    logic [7:0]  exp_keep[$];
    logic        exp_last[$];
    // Beats actually received, for literal checks.
    logic [63:0] got_data[$];
    logic [7:0]  got_keep[$];
    logic        got_last[$];

    int          m_frames = 0;
    int          m_trunc  = 0;
    logic [31:0] frm[$];
    bit          rand_mode   = 1'b0;
    bit          force_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level model: header (optional), then words paired low-first, cut at MAXW.
    task automatic model_frame();
        int n;
        n = (frm.size() > MAXW) ? MAXW : frm.size();
`ifdef TURFIO_PACKER_HEADER_EN
        exp_data.push_back({8'hA5, 6'b0, 2'(LID), 16'h0000, 32'(m_frames)});
        exp_keep.push_back(8'hFF);
        exp_last.push_back(1'b0);
`endif
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) begin
                exp_data.push_back({frm[i+1], frm[i]});
                exp_keep.push_back(8'hFF);
                exp_last.push_back(i + 2 >= n);
            end else begin
                exp_data.push_back({32'h0, frm[i]});
                exp_keep.push_back(8'h0F);
                exp_last.push_back(1'b1);
            end
        end
        if (frm.size() > MAXW && m_trunc < 65535) m_trunc++;
        m_frames++;
    endtask

    // Present one word from a negedge and hold it until accepted (bounded).
    task automatic send_word(input logic [31:0] w, input logic last);
        int  n;
        bit  acc;
        s_tvalid = 1'b1;
        s_tdata  = w;
        s_tlast  = last;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = s_tready;
            @(negedge aclk);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, n);
        end
    endtask

    task automatic send_frame();
        model_frame();
        for (int i = 0; i < frm.size(); i++) begin
            send_word(frm[i], i == frm.size() - 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_data.size() != 0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        check("drain_pending_beats", 64'(exp_data.size()), 64'd0);
        repeat (2) @(negedge aclk);
    endtask

    // Output side: drive ready, check every handshake against the model, check stall hold.
    bit          prev_stall = 1'b0;
    logic [72:0] prev_beat  = '0;
    always @(negedge aclk) begin
        m_tready = rand_mode ? ($urandom_range(0, 1) == 1) : force_ready;
        if (event_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 64'(m_tvalid), 64'd1);
                check("stall_beat_hold", 64'({m_tdata, m_tkeep, m_tlast} != prev_beat), 64'd0);
            end
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_keep.push_back(m_tkeep);
                got_last.push_back(m_tlast);
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h keep %h last %0b, none expected",
                             m_tdata, m_tkeep, m_tlast);
                end else begin
                    check("beat_data", m_tdata, exp_data.pop_front());
                    check("beat_keep", 64'(m_tkeep), 64'(exp_keep.pop_front()));
                    check("beat_last", 64'(m_tlast), 64'(exp_last.pop_front()));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tdata, m_tkeep, m_tlast};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int len;
        event_reset = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tlast     = 1'b0;
        m_tready    = 1'b1;
        repeat (3) @(negedge aclk);

        // Reset state.
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_trunc_count", 64'(trunc_count), 64'd0);
        check("rst_frame_active", 64'(frame_active), 64'd0);
        event_reset = 1'b0;
        repeat (2) @(negedge aclk);

        // 4-word frame, exactly MAXW with tlast: normal end.
        base = got_data.size();
        frm = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_frame();
        wait_drain();
        check("f4_beat0", got_data[base+HB], 64'h00000002_00000001);
        check("f4_keep0", 64'(got_keep[base+HB]), 64'hFF);
        check("f4_last0", 64'(got_last[base+HB]), 64'd0);
        check("f4_beat1", got_data[base+HB+1], 64'h00000004_00000003);
        check("f4_last1", 64'(got_last[base+HB+1]), 64'd1);
        check("f4_frame_count", 64'(frame_count), 64'd1);
        check("f4_trunc_count", 64'(trunc_count), 64'd0);
        check("f4_active_idle", 64'(frame_active), 64'd0);

        // 3-word frame: odd tail goes out as a low-half beat.
        base = got_data.size();
        frm = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        send_frame();
        wait_drain();
`ifdef TURFIO_PACKER_HEADER_EN
        check("hdr_frame2", got_data[base], 64'hA5020000_00000001);
`endif
        check("f3_beat0", got_data[base+HB], 64'hBBBB0002_AAAA0001);
        check("f3_beat1", got_data[base+HB+1], 64'h00000000_CCCC0003);
        check("f3_keep1", 64'(got_keep[base+HB+1]), 64'h0F);
        check("f3_last1", 64'(got_last[base+HB+1]), 64'd1);

        // 1-word frame immediately followed by a 2-word frame.
        base = got_data.size();
        frm = '{32'h0000_0011};
        send_frame();
        frm = '{32'h0000_0021, 32'h0000_0022};
        send_frame();
        wait_drain();
        check("f1_beat", got_data[base+HB], 64'h00000000_00000011);
        check("f1_keep", 64'(got_keep[base+HB]), 64'h0F);
        check("f1_last", 64'(got_last[base+HB]), 64'd1);
        check("b2b_beat", got_data[base+2*HB+1], 64'h00000022_00000021);
        check("b2b_frame_count", 64'(frame_count), 64'd4);

        // 7-word frame truncated at MAXW=4, then an intact frame.
        base = got_data.size();
        frm = '{32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76, 32'h77};
        send_frame();
        frm = '{32'h81, 32'h82, 32'h83};
        send_frame();
        wait_drain();
        check("tr_beat0", got_data[base+HB], 64'h00000072_00000071);
        check("tr_beat1", got_data[base+HB+1], 64'h00000074_00000073);
        check("tr_last1", 64'(got_last[base+HB+1]), 64'd1);
        check("tr_next_beat0", got_data[base+2*HB+2], 64'h00000082_00000081);
        check("tr_next_beat1", got_data[base+2*HB+3], 64'h00000000_00000083);
        check("tr_trunc_count", 64'(trunc_count), 64'd1);
        check("tr_frame_count", 64'(frame_count), 64'd6);

        // Random output stalls over many frames of mixed length.
        rand_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 9);
            frm = {};
            for (int i = 0; i < len; i++) frm.push_back($urandom());
            send_frame();
            if ($urandom_range(0, 3) == 0) @(negedge aclk);
        end
        wait_drain();
        rand_mode = 1'b0;
        check("rand_frame_count", 64'(frame_count), 64'(m_frames));
        check("rand_trunc_count", 64'(trunc_count), 64'(m_trunc));

        // Reset in the middle of a frame with beats stuck in the skid.
        force_ready = 1'b0;
        repeat (3) @(negedge aclk);
        send_word(32'h91, 1'b0);
        send_word(32'h92, 1'b0);
        send_word(32'h93, 1'b0);
        s_tvalid = 1'b0;
        @(negedge aclk);
        check("mid_pending_valid", 64'(m_tvalid), 64'd1);
        check("mid_active", 64'(frame_active), 64'd1);
        event_reset = 1'b1;
        @(negedge aclk);
        check("mrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("mrst_m_tlast", 64'(m_tlast), 64'd0);
        check("mrst_m_tdata", m_tdata, 64'd0);
        check("mrst_m_tkeep", 64'(m_tkeep), 64'd0);
        check("mrst_s_tready", 64'(s_tready), 64'd0);
        check("mrst_frame_active", 64'(frame_active), 64'd0);
        check("mrst_frame_count", 64'(frame_count), 64'd0);
        check("mrst_trunc_count", 64'(trunc_count), 64'd0);
        m_frames = 0;
        m_trunc  = 0;
        exp_data = {};
        exp_keep = {};
        exp_last = {};
        force_ready = 1'b1;
        @(negedge aclk);
        event_reset = 1'b0;
        repeat (2) @(negedge aclk);

        // First frame after reset is clean.
        base = got_data.size();
        frm = '{32'h5, 32'h6};
        send_frame();
        wait_drain();
        check("post_rst_beat", got_data[base+HB], 64'h00000006_00000005);
        check("post_rst_frame_count", 64'(frame_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
